// File: rtl/lift_seq_pkg.sv
// Shared constants and encodings for the 5/3 lifting row sequencer.
package lift_seq_pkg;

    // Widths shared with the add_mul_ram lifting datapath.
    localparam int LS_DATA_W = 26;
    localparam int LS_ADDR_W = 7;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Pass codes; the value doubles as the lf_even_odd level.
    localparam logic PASS_P = 1'b1;
    localparam logic PASS_U = 1'b0;

    // Write-back bank select carried down the alignment pipe.
    localparam logic BANK_EV = 1'b0;
    localparam logic BANK_OD = 1'b1;

endpackage

// File: rtl/lift_seq_wb.sv
// Write-back alignment pipe: delays {valid, bank, address} so that the
// write strobe lines up with the registered lifting result.
module lift_seq_wb
    import lift_seq_pkg::*;
#(
    parameter int ADDR_W = LS_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              in_bank,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic              out_bank,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int W = ADDR_W + 2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_q;
            logic [W-1:0] stage_d;

            if (gi == 0) begin : g_first
                assign stage_d = {in_vld, in_bank, in_addr};
            end else begin : g_next
                assign stage_d = g_stage[gi-1].stage_q;
            end

            // One pipe stage; reset drops any write still in flight.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign {out_vld, out_bank, out_addr} = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/lift_seq.sv
// Row sequencer for the 5/3 lifting stage: runs predict and update passes
// over an even/odd bank pair, feeding left/right/center samples with
// symmetric edge extension and writing results back in place.
module lift_seq
    import lift_seq_pkg::*;
#(
    parameter int DATA_W   = LS_DATA_W,
    parameter int ADDR_W   = LS_ADDR_W,
    parameter int N_HALF   = 64,
    parameter int LIFT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fwd_inv,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ev_raddr,
    input  logic [DATA_W-1:0] ev_rdata,
    output logic [ADDR_W-1:0] ev_waddr,
    output logic [DATA_W-1:0] ev_wdata,
    output logic              ev_we,
    output logic [ADDR_W-1:0] od_raddr,
    input  logic [DATA_W-1:0] od_rdata,
    output logic [ADDR_W-1:0] od_waddr,
    output logic [DATA_W-1:0] od_wdata,
    output logic              od_we,
    output logic [DATA_W-1:0] lf_left,
    output logic [DATA_W-1:0] lf_right,
    output logic [DATA_W-1:0] lf_center,
    output logic              lf_even_odd,
    output logic              lf_fwd_inv,
    output logic              lf_vld,
    input  logic [DATA_W-1:0] lf_res
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_HALF - 1);

    state_t            state_q, state_d;
    logic              pass_q, pass_d;
    logic              fwd_q, fwd_d;
    logic              second_q, second_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              prime_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] res_q;

    logic              wb_vld;
    logic              wb_bank;
    logic [ADDR_W-1:0] wb_addr;

    logic [DATA_W-1:0] tgt_data;
    logic [DATA_W-1:0] nbr_data;

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pass_q   <= PASS_U;
            fwd_q    <= 1'b0;
            second_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            fwd_q    <= fwd_d;
            second_q <= second_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: pass ordering and per-pass sample counter.
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        fwd_d    = fwd_q;
        second_d = second_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fwd_d    = fwd_inv;
                    pass_d   = fwd_inv ? PASS_P : PASS_U;
                    second_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = fwd_inv ? ST_PRIME : ST_RUN;
                end
            end
            ST_PRIME: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Only leave once the final write of this pass is on the
                // bank port, so the next pass never reads stale data.
                if (wb_vld && (wb_addr == LAST)) begin
                    if (second_q) begin
                        state_d = ST_FIN;
                    end else begin
                        second_d = 1'b1;
                        pass_d   = (pass_q == PASS_P) ? PASS_U : PASS_P;
                        state_d  = (pass_q == PASS_U) ? ST_PRIME : ST_RUN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read issue: target plus neighbour, right neighbour clamped at the edge.
    always_comb begin
        ev_raddr = '0;
        od_raddr = '0;
        if (state_q == ST_RUN) begin
            if (pass_q == PASS_P) begin
                od_raddr = cnt_q;
                ev_raddr = (cnt_q == LAST) ? LAST : cnt_q + 1'b1;
            end else begin
                ev_raddr = cnt_q;
                od_raddr = cnt_q;
            end
        end
    end

    // Read-data stage tracking, left-neighbour register and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            prime_q  <= 1'b0;
            left_q   <= '0;
            res_q    <= '0;
        end else begin
            rd_vld_q <= (state_q == ST_RUN);
            rd_idx_q <= cnt_q;
            prime_q  <= (state_q == ST_PRIME);
            if (prime_q) begin
                left_q <= ev_rdata;
            end else if (rd_vld_q) begin
                left_q <= lf_right;
            end
            res_q <= lf_res;
        end
    end

    // Lifting-stage operands, zero outside valid cycles.
    always_comb begin
        tgt_data    = (pass_q == PASS_P) ? od_rdata : ev_rdata;
        nbr_data    = (pass_q == PASS_P) ? ev_rdata : od_rdata;
        lf_center   = '0;
        lf_right    = '0;
        lf_left     = '0;
        lf_vld      = rd_vld_q;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_FIN);
        lf_even_odd = busy & pass_q;
        lf_fwd_inv  = busy & fwd_q;
        if (rd_vld_q) begin
            lf_center = tgt_data;
            lf_right  = nbr_data;
            // Update pass at the left edge mirrors odd[0] onto the left side.
            lf_left   = ((pass_q == PASS_U) && (rd_idx_q == '0)) ? nbr_data : left_q;
        end
    end

    lift_seq_wb #(
        .ADDR_W (ADDR_W),
        .DEPTH  (LIFT_LAT + 1)
    ) u_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd_vld_q),
        .in_bank  ((pass_q == PASS_P) ? BANK_OD : BANK_EV),
        .in_addr  (rd_idx_q),
        .out_vld  (wb_vld),
        .out_bank (wb_bank),
        .out_addr (wb_addr)
    );

    // In-place write-back of the registered lifting result.
    always_comb begin
        ev_we    = wb_vld && (wb_bank == BANK_EV);
        od_we    = wb_vld && (wb_bank == BANK_OD);
        ev_waddr = ev_we ? wb_addr : '0;
        od_waddr = od_we ? wb_addr : '0;
        ev_wdata = ev_we ? res_q : '0;
        od_wdata = od_we ? res_q : '0;
    end

endmodule

// File: doc/lift_seq.md
Name: lift_seq

Overview:
- Row sequencer for the 5/3 lifting datapath (add_mul_ram).
- Walks one row held in an even-sample bank and an odd-sample bank. Feeds the lifting stage left/right/center samples with symmetric boundary extension, and writes results back in place.
- Runs two passes per start: predict (odd update) and update (even update). Forward order is P then U; inverse order is U then P.
- Sits directly upstream of add_mul_ram and drives its pix_left/pix_right/pix_even_odd/pix_fwd_inv inputs.

Parameters:
- DATA_W, 26, sample width (matches the lifting datapath).
- ADDR_W, 7, bank address width.
- N_HALF, 64, samples per bank (row length 2*N_HALF). Legal range: 2 <= N_HALF <= 2**ADDR_W.
- LIFT_LAT, 1, fixed cycles from lf_vld to a valid lf_res (>= 1).

Ports:
- clk in 1: clock.
- rst_n in 1: reset. Synchronous, active-low.
- start in 1: begin a row. Honoured only in IDLE.
- fwd_inv in 1: 1 = forward, 0 = inverse. Sampled when start is accepted.
- busy out 1: high from the cycle after start acceptance through the done cycle.
- done out 1: one-cycle pulse when the last write of the row has completed.
- ev_raddr out ADDR_W: even bank read address. Read data returns 1 cycle later.
- ev_rdata in DATA_W: even bank read data.
- ev_waddr out ADDR_W: even bank write address.
- ev_wdata out DATA_W: even bank write data.
- ev_we out 1: even bank write strobe.
- od_raddr, od_rdata, od_waddr, od_wdata, od_we: same as the ev_* ports, for the odd bank.
- lf_left out DATA_W: left neighbour to the lifting stage.
- lf_right out DATA_W: right neighbour to the lifting stage.
- lf_center out DATA_W: sample being updated.
- lf_even_odd out 1: 1 = predict (odd target), 0 = update (even target).
- lf_fwd_inv out 1: latched fwd_inv.
- lf_vld out 1: lf_left/lf_right/lf_center are valid this cycle.
- lf_res in DATA_W: lifting result, valid LIFT_LAT cycles after the matching lf_vld.

Behaviour:
- Reset: rst_n=0 at a clk edge forces IDLE. All outputs go to 0; the internal pipeline, counters and left register are cleared.
- Reset mid-operation: any in-flight writes are dropped. Bank contents are left partially updated, with no rollback.
- Banks are simple dual-port: one read and one write per cycle, 1-cycle read latency. A write is readable from the next cycle onward.
- FSM states: IDLE, PRIME, RUN, DRAIN, FIN. A pass register selects P or U.
- IDLE:
  - start=1 latches fwd_inv and selects the first pass (P if fwd, U if inv).
  - Next state is PRIME for P, RUN for U.
  - start is ignored outside IDLE.
- PRIME (P only, 1 cycle): read even[0]. Its data loads the left register.
- RUN (N_HALF cycles, i = 0..N_HALF-1): read target[i] and a neighbour address each cycle.
  - P: neighbour is even[min(i+1, N_HALF-1)], target is odd[i].
  - U: neighbour is odd[i], target is even[i].
- Read-data cycle (issue+1):
  - lf_center = target rdata and lf_right = neighbour rdata.
  - lf_left = left register, except U with i=0, where lf_left = lf_right (mirror).
  - lf_vld=1, then left register <= lf_right.
  - P boundary (i=N_HALF-1): right mirrors to even[N_HALF-1] via the clamp.
- Write-back: lf_res is registered at issue+1+LIFT_LAT. target[i] is written at issue+2+LIFT_LAT (we high for 1 cycle).
- DRAIN: wait until the last write of the pass has been issued.
  - If this was the first pass, the second pass starts on the next cycle (PRIME or RUN). This prevents read-after-write hazards across passes.
  - If this was the second pass, go to FIN.
- FIN: done=1 for 1 cycle, then IDLE.
- Output timing:
  - lf_even_odd and lf_fwd_inv are held constant for the whole pass.
  - lf_vld pulses exactly N_HALF times per pass, back to back.
- Cycle count (start accepted at cycle 0): done asserts at cycle 2*N_HALF + 2*LIFT_LAT + 6 for both directions. busy is high in cycles 1..done.
- No arithmetic is done in this block; data passes through unmodified.

Decomposition:
- Shared package:
  - DATA_W and ADDR_W constants, shared with add_mul_ram.
  - FSM state encoding.
  - PASS_P/PASS_U codes.
- One sub-module: lift_seq_wb, a LIFT_LAT+1 deep shift register carrying {valid, target bank, address} to align write-back with lf_res.

Test Plan:
Bench lifting model: lf_res = center+left+right, with LIFT_LAT delay.
- Forward: N_HALF=4, LIFT_LAT=1, even={1,2,3,4}, odd={10,20,30,40}, fwd=1 -> odd={13,25,37,48}, even={27,40,65,89}; done at cycle 16.
- Inverse: same initial data, fwd=0 -> even={21,32,53,74}, odd={63,105,157,188}; done at cycle 16.
- Pass sequencing, forward run -> 4 back-to-back lf_vld with lf_even_odd=1, then 4 with lf_even_odd=0. lf_fwd_inv=1 throughout. Exactly one we per address per pass.
- start pulsed at cycles 5 and 12 during a busy run -> ignored, single done. start held high -> second run accepted in the cycle after FIN (first IDLE cycle).
- rst_n=0 at cycle 7 of a run -> all outputs 0 at cycle 8, no further we. A fresh start then completes with correct results on reloaded data.
- LIFT_LAT=3, N_HALF=4, forward -> same results as the first scenario; done at cycle 20.
